gate_sweep_checker: RTL and testbench
=====================================

# gate_sweep_checker

Self-checking sweep stage that wraps a two-input, one-output combinational gate: it drives the gate's inputs `a`, `b` through all four combinations, waits a programmable settle time, samples the gate output `c`, and compares each sample against an expected truth table. It sits directly upstream of the gate (drives its inputs) and directly downstream of it (consumes its output). It replaces hand-written stimulus sequences with a synthesizable, cycle-exact checker usable on the bench and on the board.

## Interface
- `EXP_TT`, default 4'b0110: expected output; bit `i` is the expected `c` for `{a,b} = i`.
- `SETTLE`, default 2: extra cycles each vector is held before sampling; legal range 0..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `start`  in  1  begin a sweep; accepted only in IDLE.
- `a`  out  1  gate input, MSB of the vector index.
- `b`  out  1  gate input, LSB of the vector index.
- `c`  in  1  gate output under test.
- `busy`  out  1  high from the cycle after `start` accept through the last sample.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `pass`  out  1  1 when the last sweep had zero mismatches; held until the next accept.
- `err_cnt`  out  3  mismatch count of the last sweep, 0..4; held until the next accept.
- `resp`  out  4  captured `c` per index; present only with `GATE_SWEEP_RESP_EN`.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE: `a=b=0`, `busy=0`. `start=1` -> DRIVE with index 0 and settle count `SETTLE`. On accept, clear `err_cnt` and `pass`.
- DRIVE: `{a,b}` = index (registered). The settle counter decrements each cycle. In the cycle it reads 0, sample `c`:
  - If `c != EXP_TT[index]`, increment `err_cnt`.
  - If index < 3: increment index and reload `SETTLE`.
  - If index = 3: go to DONE.
- DONE: `done=1` and `pass = (err_cnt==0)`, including the final sample's contribution. `busy=0`, `a=b=0`. Go to IDLE next cycle.
- `start` in DRIVE or DONE is ignored. It is not queued.
- `c` is treated as synchronous to `clk`. No synchronizer.
- `err_cnt` saturates at 4 (the maximum possible); it cannot wrap.

## Timing
- Reset values: `a=0`, `b=0`, `busy=0`, `done=0`, `pass=0`, `err_cnt=0`, `resp=0`, state IDLE.
- Start accept at edge T0: from T0 the index 0 vector is on `a,b` and `busy=1`.
- Each vector is held for exactly `SETTLE+1` cycles. `c` is sampled at the last edge of that window.
- `done` is high for the single cycle beginning 4·(`SETTLE`+1) cycles after T0. `pass`/`err_cnt` are valid from that same cycle.
- `start` held high continuously: a new sweep begins on the cycle after `done`, i.e. the IDLE cycle.
- `rst_n` low mid-sweep: all outputs return to reset values immediately (asynchronous). No `done` is produced. Resume requires a new `start`.

## Configuration
- `GATE_SWEEP_RESP_EN` defined:
  - Add port `resp[3:0]`. `resp[i]` is loaded with the sampled `c` for index `i`.
  - `resp` is cleared on accept and is complete and stable when `done` is high.
- Undefined: port and register absent. All other behaviour is identical.

## Structure
- Package `gate_sweep_pkg`:
  - State enum (IDLE, DRIVE, DONE).
  - `NVEC=4`, `IDX_W=2`, `SETTLE_W=4`, `ERR_W=3`.
- Sub-module `sweep_settle_cnt`: loadable down-counter with a zero flag.
- Top-level: FSM, index register, compare, error counter.

## Test plan
- Correct XOR gate, `EXP_TT=4'b0110`, `SETTLE=2`, one `start` pulse:
  - `a,b` run 00,01,10,11, each held 3 cycles.
  - `done` at T0+12, `pass=1`, `err_cnt=0`.
- AND gate against `EXP_TT=4'b0110`: mismatches at indices 1, 2 and 3, so `err_cnt=3`, `pass=0`. With the macro, `resp=4'b1000`.
- `c` tied 1 against `EXP_TT=4'b0000`: `err_cnt=4`, `pass=0`, no wrap.
- `SETTLE=0`, correct gate: each vector held 1 cycle, `done` at T0+4, `pass=1`.
- `start` re-pulsed during DRIVE and during DONE: both ignored, and exactly one `done` pulse is seen. With `start` held high, the next sweep begins at the IDLE cycle after `done`.
- `rst_n` dropped during index 2:
  - Immediately `a=b=0`, `busy=0`, `err_cnt=0`, and no `done`.
  - A fresh `start` yields a full correct sweep.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared sizes and FSM state encodings for the gate sweep checker
package gate_sweep_pkg;
  localparam int NVEC = 4;
  localparam int IDX_W = 2;
  localparam int SETTLE_W = 4;
  localparam int ERR_W = 3;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
endpackage

// File: rtl/gate_sweep_checker_settle_cnt.sv
// sweep_settle_cnt: loadable down-counter that stops at zero and flags it
module sweep_settle_cnt
  import gate_sweep_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                en,
  input  logic [SETTLE_W-1:0] val,
  output logic                zero
);
  logic [SETTLE_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= val;
    else if (en && cnt != '0) cnt <= cnt - SETTLE_W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps a 2-input gate through all vectors and checks c against EXP_TT
// Optional GATE_SWEEP_RESP_EN adds the per-index captured response port resp.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter logic [NVEC-1:0] EXP_TT = 4'b0110,
  parameter int              SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef GATE_SWEEP_RESP_EN
  ,
  output logic [NVEC-1:0]  resp
`endif
);
  logic [1:0] state;
  logic [IDX_W-1:0] idx;
  logic zero, accept, smp, last, mis;
  logic [ERR_W-1:0] err_nxt;
  assign accept = state == IDLE && start;
  assign smp = state == DRIVE && zero;
  assign last = idx == IDX_W'(NVEC - 1);
  assign mis = c != EXP_TT[idx];
  assign err_nxt = (mis && err_cnt != ERR_W'(NVEC)) ? err_cnt + ERR_W'(1) : err_cnt;
  assign {a, b} = state == DRIVE ? idx : '0;
  assign busy = state == DRIVE;
  assign done = state == DONE;
  sweep_settle_cnt u_settle (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept || (smp && !last)),
    .en   (state == DRIVE),
    .val  (SETTLE_W'(SETTLE)),
    .zero (zero)
  );
  // pass is decided on the final sample edge so it already includes that sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      err_cnt <= '0;
      pass <= 1'b0;
    end else if (accept) begin
      state <= DRIVE;
      idx <= '0;
      err_cnt <= '0;
      pass <= 1'b0;
    end else if (smp) begin
      err_cnt <= err_nxt;
      if (last) begin
        state <= DONE;
        pass <= err_nxt == '0;
      end else idx <= idx + IDX_W'(1);
    end else if (state != DRIVE) state <= IDLE;
`ifdef GATE_SWEEP_RESP_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) resp <= '0;
    else if (accept) resp <= '0;
    else if (smp) resp[idx] <= c;
`endif
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: directed checks of gate_sweep_checker with xor/and/stuck-1 gates
module tb_gate_sweep_checker;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
  logic a0, b0, busy0, done0, pass0;
  logic a1, b1, busy1, done1, pass1;
  logic a2, b2, busy2, done2, pass2;
  logic [2:0] err0, err1, err2;
  logic c0, c2;
  int nvec = 0, nmis = 0, dcnt;
`ifdef GATE_SWEEP_RESP_EN
  logic [3:0] resp0, resp1, resp2;
`endif
  always #5 clk = ~clk;
  assign c0 = mode ? (a0 & b0) : (a0 ^ b0);
  assign c2 = a2 ^ b2;
  gate_sweep_checker #(.EXP_TT(4'b0110), .SETTLE(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a0), .b(b0), .c(c0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0)
`ifdef GATE_SWEEP_RESP_EN
    , .resp(resp0)
`endif
  );
  gate_sweep_checker #(.EXP_TT(4'b0000), .SETTLE(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a1), .b(b1), .c(1'b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef GATE_SWEEP_RESP_EN
    , .resp(resp1)
`endif
  );
  gate_sweep_checker #(.EXP_TT(4'b0110), .SETTLE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a2), .b(b2), .c(c2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
`ifdef GATE_SWEEP_RESP_EN
    , .resp(resp2)
`endif
  );
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick(2);
    chk("rst_ab", {a0, b0}, 2'b00);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);
`ifdef GATE_SWEEP_RESP_EN
    chk("rst_resp", resp0, 0);
`endif
    rst_n = 1'b1;
    tick(1);
    // xor sweep, plus stuck-1 and SETTLE=0 instances in parallel
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("xor_ab%0d", i), {a0, b0}, 8'(i / 3));
      chk($sformatf("xor_busy%0d", i), busy0, 1);
      chk($sformatf("xor_done%0d", i), done0, 0);
      chk($sformatf("s0_done%0d", i), done2, 8'(i == 4));
      tick(1);
    end
    chk("xor_done", done0, 1);
    chk("xor_pass", pass0, 1);
    chk("xor_err", err0, 0);
    chk("xor_idle_ab", {a0, b0}, 0);
    chk("xor_idle_busy", busy0, 0);
    chk("s0_pass", pass2, 1);
    chk("s0_err", err2, 0);
    chk("one_done", done1, 1);
    chk("one_err", err1, 4);
    chk("one_pass", pass1, 0);
`ifdef GATE_SWEEP_RESP_EN
    chk("xor_resp", resp0, 4'b0110);
    chk("one_resp", resp1, 4'b1111);
`endif
    tick(3);
    chk("one_hold_err", err1, 4);
    // and gate, start re-pulsed in DRIVE and DONE
    mode = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    dcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      dcnt += int'(done0);
      if (i == 12) chk("and_done_t12", done0, 1);
      if (i == 14) chk("and_no_restart", busy0, 0);
      start = (i == 4 || i == 12);
    end
    chk("and_done_cnt", 8'(dcnt), 1);
    chk("and_err", err0, 3);
    chk("and_pass", pass0, 0);
`ifdef GATE_SWEEP_RESP_EN
    chk("and_resp", resp0, 4'b1000);
`endif
    // start held high: back-to-back sweeps
    mode = 1'b0;
    start = 1'b1;
    tick(1);
    tick(12);
    chk("hold_done", done0, 1);
    chk("hold_pass", pass0, 1);
    tick(1);
    chk("hold_idle_busy", busy0, 0);
    chk("hold_idle_done", done0, 0);
    mode = 1'b1;
    tick(1);
    chk("hold_restart_busy", busy0, 1);
    chk("hold_restart_pass", pass0, 0);
    start = 1'b0;
    tick(7);
    chk("mid_ab", {a0, b0}, 2'b10);
    chk("mid_err", err0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ab", {a0, b0}, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_err", err0, 0);
    chk("arst_done", done0, 0);
`ifdef GATE_SWEEP_RESP_EN
    chk("arst_resp", resp0, 0);
`endif
    tick(2);
    rst_n = 1'b1;
    mode = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      dcnt += int'(done0);
    end
    chk("arst_no_done", 8'(dcnt), 0);
    chk("arst_no_busy", busy0, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(12);
    chk("fresh_done", done0, 1);
    chk("fresh_pass", pass0, 1);
    chk("fresh_err", err0, 0);
    tick(1);
    chk("fresh_done_pulse", done0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
